// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - stopwatch sequencer state encoding
package stopwatch_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_LAP     = 3'd3,
    ST_FULL    = 3'd4
  } state_t;

endpackage

// File: rtl/rise_pulse.sv
// rtl/rise_pulse.sv - registered rising-edge detector, one pulse per button press
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_pulse
);

  logic r_q;
  logic r_pulse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q     <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_q     <= i_in;
      r_pulse <= i_in & ~r_q;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/clear/lap sequencer and tick prescaler for the BCD chain
// Optional lap view enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               lap,
  input  logic               top_threshold,
  output logic               count_enable,
  output logic               count_clear,
  output logic               display_hold,
  output logic               running,
  output logic [STATE_W-1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic    w_ss_evt, w_clr_evt, w_lap_raw, w_lap_evt;
  logic    w_run, w_tick;
  state_t  r_state, w_next;
  logic [PW-1:0] r_presc, w_presc_next;
  logic    r_ce, w_ce_next;
  logic    r_cc, w_cc_next;

  rise_pulse u_ss  (.clk(clk), .rst(rst), .i_in(start_stop), .o_pulse(w_ss_evt));
  rise_pulse u_clr (.clk(clk), .rst(rst), .i_in(clear),      .o_pulse(w_clr_evt));
  rise_pulse u_lap (.clk(clk), .rst(rst), .i_in(lap),        .o_pulse(w_lap_raw));

  assign w_lap_evt = w_lap_raw & LAP_EN;
  assign w_run     = (r_state == ST_RUNNING) || (r_state == ST_LAP);
  assign w_tick    = w_run && (r_presc == PMAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_ce    <= 1'b0;
      r_cc    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_presc <= w_presc_next;
      r_ce    <= w_ce_next;
      r_cc    <= w_cc_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_ce_next    = 1'b0;
    w_cc_next    = 1'b0;
    w_presc_next = r_presc;
    if (w_run) begin
      w_presc_next = w_tick ? '0 : r_presc + 1'b1;
    end
    if (w_clr_evt) begin
      w_next       = ST_IDLE;
      w_cc_next    = 1'b1;
      w_presc_next = '0;
    end else if (w_tick && top_threshold) begin
      // chain already at max: hold it there instead of rolling over
      w_next = ST_FULL;
    end else begin
      w_ce_next = w_tick;
      case (r_state)
        ST_IDLE: begin
          if (w_ss_evt) begin
            w_next       = ST_RUNNING;
            w_presc_next = '0;
          end
        end
        ST_RUNNING: begin
          if (w_ss_evt)       w_next = ST_PAUSED;
          else if (w_lap_evt) w_next = ST_LAP;
        end
        ST_PAUSED: begin
          if (w_ss_evt) w_next = ST_RUNNING;
        end
        ST_LAP: begin
          if (w_ss_evt)       w_next = ST_PAUSED;
          else if (w_lap_evt) w_next = ST_RUNNING;
        end
        ST_FULL: w_next = ST_FULL;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  assign count_enable = r_ce;
  assign count_clear  = r_cc;
  assign running      = w_run;
  assign display_hold = LAP_EN && (r_state == ST_LAP);
  assign state        = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl (DIV=10)
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic       top_threshold = 1'b0;
  logic       count_enable, count_clear, display_hold, running;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .top_threshold(top_threshold), .count_enable(count_enable),
    .count_clear(count_clear), .display_hold(display_hold),
    .running(running), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press_ss();
    start_stop = 1'b1; step(1); start_stop = 1'b0; step(1);
  endtask

  task automatic press_clr();
    clear = 1'b1; step(1); clear = 1'b0; step(1);
  endtask

  task automatic wait_ce(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!count_enable && n < 50);
  endtask

  task automatic count_ce(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      step(1);
      if (count_enable) pulses++;
    end
  endtask

  initial begin
    int n;
    int k;
    int trans;
    logic [2:0] prev;

    step(3);
    check("rst_state", state, 0);
    check("rst_outputs", {count_enable, count_clear, display_hold, running}, 0);
    rst = 1'b1;
    step(1);

    // 1: start, first tick after 10 cycles, then every 10
    press_ss();
    check("t1_state", state, 1);
    check("t1_running", running, 1);
    wait_ce(n);
    check("t1_first_ce", n, 10);
    count_ce(9, k);
    check("t1_gap_quiet", k, 0);
    step(1);
    check("t1_second_ce", count_enable, 1);

    // 2: pause after 25 running cycles, resume finishes the sub-tick
    step(3);
    press_ss();
    check("t2_paused", state, 2);
    check("t2_not_running", running, 0);
    count_ce(50, k);
    check("t2_pause_quiet", k, 0);
    press_ss();
    check("t2_resumed", state, 1);
    wait_ce(n);
    check("t2_remaining", n, 5);

    // 3: clear beats start_stop
    start_stop = 1'b1; clear = 1'b1;
    step(1);
    start_stop = 1'b0; clear = 1'b0;
    step(1);
    check("t3_state", state, 0);
    check("t3_cc", count_clear, 1);
    check("t3_ce", count_enable, 0);
    step(1);
    check("t3_cc_one_cycle", count_clear, 0);
    count_ce(20, k);
    check("t3_idle_quiet", k, 0);

    // 4: saturation
    press_ss();
    top_threshold = 1'b1;
    step(10);
    check("t4_full", state, 4);
    check("t4_ce_blocked", count_enable, 0);
    check("t4_not_running", running, 0);
    press_ss();
    check("t4_ss_ignored", state, 4);
    top_threshold = 1'b0;
    press_clr();
    check("t4_clear_idle", state, 0);
    check("t4_cc", count_clear, 1);

    // 5: lap view
    press_ss();
    lap = 1'b1; step(1); lap = 1'b0; step(1);
`ifdef STOPWATCH_LAP_EN
    check("t5_lap_state", state, 3);
    check("t5_hold", display_hold, 1);
`else
    check("t5_lap_state", state, 1);
    check("t5_hold", display_hold, 0);
`endif
    check("t5_running", running, 1);
    step(8);
    check("t5_ce_continues", count_enable, 1);
    press_ss();
    check("t5_paused", state, 2);
    check("t5_hold_drop", display_hold, 0);

    // 6: held button gives one transition; async reset mid-run
    press_clr();
    check("t6_idle", state, 0);
    start_stop = 1'b1;
    trans = 0;
    k = 0;
    prev = state;
    repeat (100) begin
      step(1);
      if (state !== prev) trans++;
      if (count_enable) k++;
      prev = state;
    end
    check("t6_one_transition", trans, 1);
    check("t6_state_running", state, 1);
    check("t6_ce_count", k, 9);
    start_stop = 1'b0;
    step(2);
    check("t6_ce_before_rst", count_enable, 1);
    rst = 1'b0;
    #2;
    check("t6_async_state", state, 0);
    check("t6_async_outputs", {count_enable, count_clear, display_hold, running}, 0);
    step(1);
    rst = 1'b1;
    step(2);
    check("t6_after_rst", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
